// File: rtl/uart_tx_basic_pkg.sv
// Shared definitions for the basic UART transmitter: state encoding, default
// frame parameters and a counter-width helper.
package uart_tx_basic_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } tx_state_e;

  localparam int unsigned DefDataW      = 8;
  localparam int unsigned DefClksPerBit = 4;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_basic_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_tx_basic_bit_timer
  import uart_tx_basic_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned          CntW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0]      CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_basic.sv
// UART-style serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each held CLKS_PER_BIT cycles. tx and busy are registered from the current state.
module uart_tx_basic
  import uart_tx_basic_pkg::*;
#(
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned     BitW   = cnt_width(DATA_W);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              timer_clear;

  // Restart the bit period whenever the frame moves to a new field.
  assign timer_clear = (state_d != state_q);

  uart_tx_basic_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      StIdle: begin
        if (valid) begin
          shift_d = data_in;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitMax) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    case (state_q)
      StStart: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      StData: begin
        tx_d   = shift_q[0];
        busy_d = 1'b1;
      end
      StStop: begin
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_basic.sv
// Scoreboard bench for uart_tx_basic: accepted words are queued, a line monitor
// decodes frames on tx and compares them against the expected frame shape.
module tb_uart_tx_basic;

  localparam int DW       = 8;
  localparam int CPB      = 4;
  localparam int FrameCyc = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready, tx, busy;

  logic          valid1 = 1'b0;
  logic [0:0]    data1 = '0;
  logic          ready1, tx1, busy1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k = -1;
  logic [DW-1:0] exp_q[$];
  int start_times[$];

  uart_tx_basic #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .tx     (tx),
    .busy   (busy)
  );

  uart_tx_basic #(
    .DATA_W      (1),
    .CLKS_PER_BIT(1)
  ) u_dut_small (
    .clk    (clk),
    .rst    (rst),
    .data_in(data1),
    .valid  (valid1),
    .ready  (ready1),
    .tx     (tx1),
    .busy   (busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Line monitor: frame = start 0, data LSB first, stop 1, each CPB cycles.
  initial begin
    logic [DW+1:0] frame;
    logic [DW-1:0] word;
    int            bad;
    int            bad_k;
    logic [2:0]    bad_got, bad_exp;
    logic [2:0]    got, exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = -1;
      end else if (k < 0) begin
        if (tx === 1'b0 && exp_q.size() != 0) begin
          word  = exp_q.pop_front();
          frame = {1'b1, word, 1'b0};
          k     = 0;
          bad   = 0;
          bad_k = -1;
          start_times.push_back(cyc);
        end else begin
          chk("idle_line_tx_busy", int'({tx, busy}), 2);
        end
      end
      if (!rst && k >= 0) begin
        got = {tx, busy, ready};
        exp = {frame[k / CPB], 1'b1, (k == FrameCyc - 1)};
        if (got !== exp) begin
          if (bad == 0) begin
            bad_k   = k;
            bad_got = got;
            bad_exp = exp;
          end
          bad++;
        end
        k++;
        if (k == FrameCyc) begin
          checks++;
          if (bad != 0) begin
            failures++;
            $display("FAIL frame %h: %0d bad cycles, first k=%0d tx/busy/ready got %b expected %b",
                     word, bad, bad_k, bad_got, bad_exp);
          end
          k = -1;
        end
      end
    end
  end

  // Present a word and hold valid until the DUT can take it; call at a negedge.
  task automatic send(input logic [DW-1:0] w, input bit keep);
    int n;
    valid   = 1'b1;
    data_in = w;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", n, 0);
      valid = 1'b0;
    end else begin
      exp_q.push_back(w);
      @(negedge clk);
      if (!keep) valid = 1'b0;
      data_in = DW'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || k >= 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_within_budget", int'(n < 4000), 1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [3:0] seq_tx, seq_busy;

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(ready), 1);
    rst = 1'b0;

    // Quiet line after reset.
    repeat (100) begin
      @(negedge clk);
      chk("idle_after_reset", int'({tx, busy, ready}), 3'b101);
    end

    send(8'hA5, 1'b0);
    drain();

    // Back-to-back with valid held.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    drain();
    chk("b2b_start_spacing", start_times[$] - start_times[$-1], FrameCyc + 1);

    // Junk on valid/data_in while busy must not alter or add frames.
    send(DW'($urandom), 1'b0);
    repeat (25) begin
      @(negedge clk);
      valid   = 1'($urandom);
      data_in = DW'($urandom);
    end
    valid = 1'b0;
    drain();

    // Reset part-way through the fourth data bit.
    send(DW'($urandom), 1'b0);
    n = 0;
    while (k < 17 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mid_frame", int'(k >= 17), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_tx", int'(tx), 1);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_ready", int'(ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_after_abort", int'({tx, busy, ready}), 3'b101);
    end

    // Random traffic with random gaps and back-to-back runs.
    for (int i = 0; i < 30; i++) begin
      bit keep;
      keep = (i == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      send(DW'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    // Minimal configuration: one data bit, one cycle per bit.
    for (int d = 1; d >= 0; d--) begin
      valid1 = 1'b1;
      data1  = 1'(d);
      n = 0;
      while (ready1 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("small_ready", int'(ready1), 1);
      @(negedge clk);
      valid1 = 1'b0;
      chk("small_tx_before_start", int'(tx1), 1);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        seq_tx[3-c]   = tx1;
        seq_busy[3-c] = busy1;
      end
      chk("small_tx_seq", int'(seq_tx), int'({1'b0, 1'(d), 1'b1, 1'b1}));
      chk("small_busy_seq", int'(seq_busy), 4'b1110);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
